// File: rtl/dma_rd_engine.sv
// -----------------------------------------------------------------------------
// dma_rd_engine
//   Source-side DMA read engine. It reads len_words 32-bit words, starting at
//   src_addr, over an ICB-style master port with one request in flight. Each
//   good response is pushed straight into the downstream 16x32 FIFO. No new
//   command is presented while that FIFO reports full.
//
//   Optional feature: define DMA_RD_ABORT_EN to add the `abort` input, which
//   ends a transfer early. Without it, a transfer runs until every word is
//   read or a bus error occurs.
// -----------------------------------------------------------------------------
module dma_rd_engine #(
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int LENW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
`ifdef DMA_RD_ABORT_EN
   input  logic            abort,
`endif
   input  logic [AW-1:0]   src_addr,
   input  logic [LENW-1:0] len_words,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [LENW-1:0] xfer_cnt,
   output logic            icb_cmd_valid,
   input  logic            icb_cmd_ready,
   output logic [AW-1:0]   icb_cmd_addr,
   output logic            icb_cmd_read,
   input  logic            icb_rsp_valid,
   output logic            icb_rsp_ready,
   input  logic [DW-1:0]   icb_rsp_rdata,
   input  logic            icb_rsp_err,
   output logic            fifo_w_en,
   output logic [DW-1:0]   fifo_data_w,
   input  logic            fifo_full
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD,
      S_RSP,
      S_DONE
   } state_e;

   state_e          state_q;
   logic [AW-1:0]   addr_q;
   logic [LENW-1:0] rem_q;
   logic [LENW-1:0] xfer_cnt_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;
   logic            rsp_ready_q;
   logic            abort_pend_q;

   logic            abort_w;
   logic            cmd_fire;
   logic            rsp_fire;

`ifdef DMA_RD_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // The FIFO can only drain while a command waits (no response is in flight),
   // so once fifo_full drops the valid stays up until the handshake completes.
   // An abort withdraws the command before any handshake can happen.
   assign icb_cmd_valid = (state_q == S_CMD) && !fifo_full && !abort_w;
   assign icb_cmd_addr  = addr_q;
   assign icb_cmd_read  = 1'b1;
   assign icb_rsp_ready = rsp_ready_q;

   assign cmd_fire  = icb_cmd_valid && icb_cmd_ready;
   assign rsp_fire  = rsp_ready_q && icb_rsp_valid;

   // Push in the same cycle the response is accepted; data passes straight through.
   assign fifo_w_en   = rsp_fire && !icb_rsp_err;
   assign fifo_data_w = icb_rsp_rdata;

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign xfer_cnt = xfer_cnt_q;

   // Transfer FSM: state, address/length counters and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         rem_q        <= '0;
         xfer_cnt_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         rsp_ready_q  <= 1'b0;
         abort_pend_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below reads
         // the pre-edge register values regardless of statement order.
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_q     <= src_addr & ~AW'(3);
                  rem_q      <= len_words;
                  xfer_cnt_q <= '0;
                  err_q      <= 1'b0;
                  busy_q     <= 1'b1;
                  if (len_words == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_CMD;
                  end
               end
            end

            S_CMD: begin
               if (abort_w) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else if (cmd_fire) begin
                  state_q     <= S_RSP;
                  rsp_ready_q <= 1'b1;
               end
            end

            S_RSP: begin
               // An abort seen while waiting is remembered until the response lands.
               if (abort_w) begin
                  abort_pend_q <= 1'b1;
               end
               if (rsp_fire) begin
                  rsp_ready_q <= 1'b0;
                  if (icb_rsp_err) begin
                     err_q   <= 1'b1;
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     addr_q     <= addr_q + AW'(4);
                     rem_q      <= rem_q - LENW'(1);
                     xfer_cnt_q <= xfer_cnt_q + LENW'(1);
                     if ((rem_q == LENW'(1)) || abort_w || abort_pend_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= S_CMD;
                     end
                  end
               end
            end

            S_DONE: begin
               state_q      <= S_IDLE;
               busy_q       <= 1'b0;
               abort_pend_q <= 1'b0;
            end

            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               rsp_ready_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_rd_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_rd_engine
//   Drives dma_rd_engine with a behavioural ICB slave and FIFO occupancy model.
//   Expected command addresses, pushed words, counts and status are derived
//   from the transfer parameters (base, length, error position, abort point).
//   Define DMA_RD_ABORT_EN for both files to exercise the abort input.
// -----------------------------------------------------------------------------
module tb_dma_rd_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [31:0] src_addr;
   logic [15:0] len_words;
   logic        busy, done, err;
   logic [15:0] xfer_cnt;
   logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
   logic [31:0] icb_cmd_addr;
   logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
   logic [31:0] icb_rsp_rdata;
   logic        fifo_w_en, fifo_full;
   logic [31:0] fifo_data_w;

   int n_checks = 0;
   int n_errors = 0;
   int fifo_cnt;

   always #5 clk = ~clk;

   dma_rd_engine #(.AW(32), .DW(32), .LENW(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
`ifdef DMA_RD_ABORT_EN
      .abort         (abort),
`endif
      .src_addr      (src_addr),
      .len_words     (len_words),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .xfer_cnt      (xfer_cnt),
      .icb_cmd_valid (icb_cmd_valid),
      .icb_cmd_ready (icb_cmd_ready),
      .icb_cmd_addr  (icb_cmd_addr),
      .icb_cmd_read  (icb_cmd_read),
      .icb_rsp_valid (icb_rsp_valid),
      .icb_rsp_ready (icb_rsp_ready),
      .icb_rsp_rdata (icb_rsp_rdata),
      .icb_rsp_err   (icb_rsp_err),
      .fifo_w_en     (fifo_w_en),
      .fifo_data_w   (fifo_data_w),
      .fifo_full     (fifo_full)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Contents of source memory: a fixed scramble of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   task automatic drive_idle();
      start         = 1'b0;
      abort         = 1'b0;
      icb_cmd_ready = 1'b0;
      icb_rsp_valid = 1'b0;
      icb_rsp_err   = 1'b0;
      icb_rsp_rdata = $urandom;
      src_addr      = $urandom;
      len_words     = 16'($urandom);
   endtask

   // One transfer. fast: slave always ready, zero response delay, FIFO popped
   // every cycle. stall: FIFO never popped before cycle 60. err_at: 1-based
   // response that returns an error (0 = none). abort_at: cycle of abort pulse.
   task automatic run_xfer(input logic [31:0] base, input logic [15:0] len,
                           input int err_at, input bit fast, input bit stall,
                           input bit restart_probe, input int abort_at);
      logic [31:0] a0;
      logic [31:0] pend_addr;
      bit          pend, got_done, pop;
      int          dly, n_cmd, n_push, n_rsp, cyc, lat;
      int          exp_cmds, exp_words;
      bit          exp_err;

      a0        = base & 32'hFFFF_FFFC;
      exp_err   = (err_at > 0) && (err_at <= int'(len));
      exp_cmds  = exp_err ? err_at : int'(len);
      exp_words = exp_err ? err_at - 1 : int'(len);
      if (abort_at > 0) begin
         exp_cmds  = abort_at / 2;
         exp_words = abort_at / 2;
      end
      fifo_cnt = 0;
      pend = 0; dly = 0; pend_addr = '0;
      n_cmd = 0; n_push = 0; n_rsp = 0; got_done = 0; lat = 0;

      @(negedge clk);
      drive_idle();
      fifo_full = 1'b0;
      start     = 1'b1;
      src_addr  = base;
      len_words = len;
      cyc = 0;

      while (!got_done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         // Stimulus for this cycle
         fifo_full     = (fifo_cnt >= 16);
         start         = restart_probe && (cyc == 3);
         src_addr      = $urandom;
         len_words     = 16'($urandom_range(1, 40));
         abort         = (abort_at > 0) && (cyc == abort_at);
         icb_cmd_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
         if (abort) icb_cmd_ready = 1'b0;
         if (pend && dly == 0) begin
            icb_rsp_valid = 1'b1;
            icb_rsp_rdata = mem_word(pend_addr);
            icb_rsp_err   = (n_rsp + 1 == err_at);
         end else begin
            icb_rsp_valid = 1'b0;
            icb_rsp_rdata = $urandom;
            icb_rsp_err   = 1'b0;
         end
         pop = stall ? (cyc >= 60) : (fast ? 1'b1 : 1'($urandom_range(0, 1)));
         #1;
         // Observation
         if (cyc == 1) begin
            check("busy_after_start", busy, 1);
            check("err_cleared_on_start", err, 0);
            check("xfer_cnt_cleared", xfer_cnt, 0);
         end
         if (restart_probe && cyc == 3) check("busy_at_restart", busy, 1);
         if (abort) check("valid_dropped_on_abort", icb_cmd_valid, 0);
         if (fifo_full) begin
            check("no_cmd_while_full", icb_cmd_valid, 0);
            check("no_push_while_full", fifo_w_en, 0);
         end
         if (stall && cyc == 59) begin
            check("stall_pushes", n_push, 16);
            check("stall_no_cmd", icb_cmd_valid, 0);
         end
         if (stall && cyc == 61) check("cmd_after_pop", icb_cmd_valid, 1);
         if (pend && dly > 0) dly--;
         if (icb_rsp_valid && icb_rsp_ready) begin
            n_rsp++;
            pend = 0;
            if (icb_rsp_err) begin
               check("no_push_on_err", fifo_w_en, 0);
            end else begin
               check("push_on_rsp", fifo_w_en, 1);
               check("push_data", fifo_data_w, mem_word(a0 + 32'(n_push) * 32'd4));
               n_push++;
               fifo_cnt++;
            end
         end else begin
            check("no_stray_push", fifo_w_en, 0);
         end
         if (icb_cmd_valid && icb_cmd_ready) begin
            check("cmd_within_count", 32'(n_cmd < exp_cmds), 1);
            check("cmd_addr", icb_cmd_addr, a0 + 32'(n_cmd) * 32'd4);
            check("cmd_read", icb_cmd_read, 1);
            n_cmd++;
            pend      = 1;
            pend_addr = icb_cmd_addr;
            dly       = fast ? 0 : $urandom_range(0, 3);
         end
         if (pop && fifo_cnt > 0) fifo_cnt--;
         if (done) begin
            got_done = 1;
            lat      = cyc;
         end
      end

      check("done_seen", got_done, 1);
      if (fast && !stall && !exp_err && abort_at == 0) check("done_latency", lat, 2 * int'(len) + 1);
      if (abort_at > 0) check("abort_done_latency", lat, abort_at + 1);
      check("cmd_count", n_cmd, exp_cmds);
      check("push_count", n_push, exp_words);
      check("xfer_cnt_final", xfer_cnt, exp_words);
      check("err_final", err, exp_err);

      @(negedge clk);
      drive_idle();
      fifo_full = 1'b0;
      #1;
      check("done_one_cycle", done, 0);
      check("idle_not_busy", busy, 0);
      check("idle_no_cmd", icb_cmd_valid, 0);
      check("err_sticky", err, exp_err);
   endtask

   // Reset while the second response is outstanding.
   task automatic reset_mid_rsp();
      @(negedge clk);
      drive_idle();
      fifo_full     = 1'b0;
      start         = 1'b1;
      src_addr      = 32'h0000_2000;
      len_words     = 16'd3;
      icb_cmd_ready = 1'b1;
      @(negedge clk);                 // CMD, word 0
      start = 1'b0;
      @(negedge clk);                 // RSP, word 0
      icb_rsp_valid = 1'b1;
      icb_rsp_rdata = mem_word(32'h0000_2000);
      #1 check("rst_pre_push", fifo_w_en, 1);
      @(negedge clk);                 // CMD, word 1
      icb_rsp_valid = 1'b0;
      @(negedge clk);                 // RSP, word 1 pending
      #1;
      check("rst_pre_rsp_ready", icb_rsp_ready, 1);
      check("rst_pre_xfer_cnt", xfer_cnt, 1);
      rst_n         = 1'b0;
      icb_rsp_valid = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_xfer_cnt", xfer_cnt, 0);
      check("rst_cmd_valid", icb_cmd_valid, 0);
      check("rst_rsp_ready", icb_rsp_ready, 0);
      check("rst_w_en", fifo_w_en, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("late_rsp_not_pushed", fifo_w_en, 0);
         check("late_rsp_not_ready", icb_rsp_ready, 0);
         check("late_rsp_idle", busy, 0);
      end
      icb_rsp_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      drive_idle();
      fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_err", err, 0);
      check("reset_xfer_cnt", xfer_cnt, 0);
      check("reset_cmd_valid", icb_cmd_valid, 0);
      check("reset_rsp_ready", icb_rsp_ready, 0);
      rst_n = 1'b1;

      run_xfer(32'h0000_1000, 16'd4, 0, 1'b1, 1'b0, 1'b0, 0);   // basic
      run_xfer(32'h0000_4000, 16'd20, 0, 1'b1, 1'b1, 1'b0, 0);  // backpressure
      run_xfer(32'h0000_8000, 16'd5, 3, 1'b0, 1'b0, 1'b0, 0);   // bus error
      run_xfer(32'h0000_0123, 16'd0, 0, 1'b1, 1'b0, 1'b0, 0);   // zero length
      run_xfer(32'h0000_3000, 16'd6, 0, 1'b1, 1'b0, 1'b1, 0);   // start while busy
      run_xfer(32'hFFFF_FFFE, 16'd2, 0, 1'b1, 1'b0, 1'b0, 0);   // align and wrap
      reset_mid_rsp();
      for (int t = 0; t < 8; t++) begin
         logic [15:0] l;
         int          e;
         l = 16'($urandom_range(1, 24));
         e = ($urandom_range(0, 2) == 0) ? $urandom_range(1, int'(l)) : 0;
         run_xfer($urandom, l, e, 1'b0, 1'b0, 1'b0, 0);
      end
`ifdef DMA_RD_ABORT_EN
      run_xfer(32'h0000_5000, 16'd8, 0, 1'b1, 1'b0, 1'b0, 5);   // abort in CMD
      run_xfer(32'h0000_6000, 16'd8, 0, 1'b1, 1'b0, 1'b0, 4);   // abort in RSP
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
